// File: rtl/spi_master_if.sv
// spi_master_if: bundles the host word handshake and the four-wire SPI link
// of one SPI mode-0 initiator.
//
// Signals:
//   data_in_valid / data_in     host request and word to transmit
//   busy                        transaction in flight (accept .. end of gap)
//   data_out_valid / data_out   one-cycle pulse with the received word
//   sck / cs / mosi / miso      SPI link (cs active-low)
//   dbg_state                   current FSM state of the initiator
//
// Handshake: a word is accepted in the cycle where data_in_valid=1 and the
// initiator is idle (busy=0); requests while busy=1 are dropped, never
// queued. data_out_valid is a single-cycle pulse with no back-pressure.
//
// Modports: master = the initiator itself, slave = the host driving it.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  data_out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  sck;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [2:0]            dbg_state;

  modport master (
    input  data_in_valid, data_in, miso,
    output busy, data_out_valid, data_out, sck, cs, mosi, dbg_state
  );

  modport slave (
    output data_in_valid, data_in, miso,
    input  busy, data_out_valid, data_out, sck, cs, mosi, dbg_state
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator (CPOL=0, CPHA=0), MSB first, one
// full-duplex word per transaction.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  spi_master_if.master (host handshake, SPI pins, debug state)
//
// Frame shape (T = accept cycle, D = CLK_DIV, N = DATA_WIDTH):
//   T+1           cs low, first bit on mosi, SETUP
//   T+1+D*(1+2k)  sck rises, miso sampled in that cycle
//   T+1+D*(2+2k)  sck falls, next bit on mosi
//   T+1+D*(2N+1)  cs high, data_out loaded, data_out_valid pulse, GAP
//   T+1+D*(2N+2)  busy low, back to IDLE
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input logic        clk,
  input logic        rst,
  spi_master_if.master bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  sck_q, sck_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  dov_q, dov_d;
  logic                  wrap;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    dov_d      = 1'b0;

    // Half-period counter: held at zero while idle so every frame starts
    // its first half-period aligned to the accept cycle.
    wrap = (cnt_q == CNT_LAST);
    if (state_q == S_IDLE || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.data_in_valid) begin
          tx_d      = bus.data_in;
          rx_d      = '0;
          bit_cnt_d = '0;
          mosi_d    = bus.data_in[DATA_WIDTH-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (wrap) begin
          sck_d   = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // First cycle of each sck-high phase: capture miso. It was launched
        // by the slave a half period earlier, so it is settled here.
        if (sck_q && cnt_q == '0) begin
          rx_d = {rx_q[DATA_WIDTH-2:0], bus.miso};
        end
        if (wrap) begin
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              // Last falling edge: bit 0 stays on mosi through HOLD.
              state_d = S_HOLD;
            end else begin
              tx_d      = tx_q << 1;
              mosi_d    = tx_q[DATA_WIDTH-2];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            sck_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (wrap) begin
          cs_d       = 1'b1;
          mosi_d     = 1'b0;
          data_out_d = rx_q;
          dov_d      = 1'b1;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if (wrap) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      dov_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      dov_q      <= dov_d;
    end
  end

  assign bus.sck            = sck_q;
  assign bus.cs             = cs_q;
  assign bus.mosi           = mosi_q;
  assign bus.busy           = busy_q;
  assign bus.data_out_valid = dov_q;
  assign bus.data_out       = data_out_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master. Instance A uses the default shape
// (8-bit, CLK_DIV=4) with either loopback or a behavioural slave on miso;
// instance B uses 16-bit, CLK_DIV=2 in loopback. Expected event cycles are
// computed from the frame-timing formulas relative to the accept cycle.
module tb_spi_master;
  localparam int DW   = 8;
  localparam int CD   = 4;
  localparam int DW_B = 16;
  localparam int CD_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  spi_master_if #(.DATA_WIDTH(DW))   if_a ();
  spi_master_if #(.DATA_WIDTH(DW_B)) if_b ();

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  spi_master #(.DATA_WIDTH(DW_B), .CLK_DIV(CD_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // ---------------- scoreboard counters / checker ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model / miso source for A ----------------
  bit            loop_a = 1'b1;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] s_sh = '0;
  logic [DW-1:0] s_rx = '0;

  always @(negedge if_a.cs) begin
    s_sh = slave_word;
    s_rx = '0;
  end
  always @(posedge if_a.sck) s_rx = {s_rx[DW-2:0], if_a.mosi};
  always @(negedge if_a.sck) s_sh = s_sh << 1;

  assign if_a.miso = loop_a ? if_a.mosi : s_sh[DW-1];
  assign if_b.miso = if_b.mosi;

  // ---------------- monitor A (events relative to accept cycle) ----------------
  int t0 = 0;
  bit mon_en = 1'b0;
  int rise_q[$], fall_q[$], csf_q[$], csr_q[$], busyf_q[$], dov_q[$];
  logic [DW-1:0] dovd_q[$];
  logic [31:0] mosi_word;
  int mosi_bad, viol;
  logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;

  // mosi may only move at cs assertion, at a non-final sck fall, or at cs release.
  function automatic bit mosi_change_ok(input int c, input int cd, input int dw);
    if (c == 1 || c == 1 + cd * (2 * dw + 1)) return 1'b1;
    for (int k = 0; k < dw - 1; k++) begin
      if (c == 1 + cd * (2 + 2 * k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (mon_en) begin
      if (if_a.sck && !p_sck) begin
        rise_q.push_back(rel);
        mosi_word = (mosi_word << 1) | 32'(if_a.mosi);
      end
      if (!if_a.sck && p_sck) fall_q.push_back(rel);
      if (!if_a.cs && p_cs) csf_q.push_back(rel);
      if (if_a.cs && !p_cs) csr_q.push_back(rel);
      if (!if_a.busy && p_busy) busyf_q.push_back(rel);
      if (if_a.data_out_valid) begin
        dov_q.push_back(rel);
        dovd_q.push_back(if_a.data_out);
      end
      if (if_a.mosi != p_mosi && !mosi_change_ok(rel, CD, DW)) mosi_bad++;
      if (if_a.sck && if_a.cs) viol++;
    end
    p_sck  = if_a.sck;
    p_cs   = if_a.cs;
    p_mosi = if_a.mosi;
    p_busy = if_a.busy;
  end

  task automatic clear_mon_a();
    rise_q.delete(); fall_q.delete(); csf_q.delete(); csr_q.delete();
    busyf_q.delete(); dov_q.delete(); dovd_q.delete();
    mosi_word = '0;
    mosi_bad  = 0;
    viol      = 0;
  endtask

  // ---------------- monitor B ----------------
  int t0_b = 0;
  bit mon_b = 1'b0;
  int rises_b, dov_n_b, dov_at_b, busyf_b;
  logic [DW_B-1:0] dout_b;
  logic [31:0] mosi_word_b;
  logic pb_sck = 1'b0, pb_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_b) begin
      if (if_b.sck && !pb_sck) begin
        rises_b++;
        mosi_word_b = (mosi_word_b << 1) | 32'(if_b.mosi);
      end
      if (if_b.data_out_valid) begin
        dov_n_b++;
        dov_at_b = cyc - t0_b;
        dout_b   = if_b.data_out;
      end
      if (!if_b.busy && pb_busy) busyf_b = cyc - t0_b;
    end
    pb_sck  = if_b.sck;
    pb_busy = if_b.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle_a();
    int n;
    n = 0;
    while (if_a.busy === 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("idle_wait_a", 32'(if_a.busy), 32'd0);
  endtask

  // Pulse data_in_valid for one cycle (cycle T = t0), then scramble data_in
  // so any re-sampling during the frame would corrupt mosi.
  task automatic start_a(input logic [DW-1:0] d);
    wait_idle_a();
    @(posedge clk); #1;
    clear_mon_a();
    if_a.data_in       = d;
    if_a.data_in_valid = 1'b1;
    t0     = cyc;
    mon_en = 1'b1;
    @(posedge clk); #1;
    if_a.data_in_valid = 1'b0;
    if_a.data_in       = DW'($urandom);
  endtask

  task automatic frame_a(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] sw,
                         input bit loop, input int extra_at);
    logic [DW-1:0] exp_rx;
    loop_a     = loop;
    slave_word = sw;
    exp_rx     = loop ? d : sw;
    start_a(d);
    for (int i = 2; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == extra_at) begin
        if_a.data_in_valid = 1'b1;
        if_a.data_in       = 8'h11;
      end else begin
        if_a.data_in_valid = 1'b0;
      end
    end
    mon_en = 1'b0;
    check({tag, ".rises"}, 32'(rise_q.size()), 32'(DW));
    for (int k = 0; k < rise_q.size() && k < DW; k++) begin
      check($sformatf("%s.rise%0d", tag, k), 32'(rise_q[k]), 32'(1 + CD * (1 + 2 * k)));
    end
    check({tag, ".last_fall"}, (fall_q.size() > 0) ? 32'(fall_q[$]) : 32'hFFFF_FFFF,
          32'(1 + CD * 2 * DW));
    check({tag, ".cs_falls"}, 32'(csf_q.size()), 32'd1);
    check({tag, ".cs_fall_at"}, (csf_q.size() > 0) ? 32'(csf_q[0]) : 32'hFFFF_FFFF, 32'd1);
    check({tag, ".cs_rise_at"}, (csr_q.size() > 0) ? 32'(csr_q[0]) : 32'hFFFF_FFFF,
          32'(1 + CD * (2 * DW + 1)));
    check({tag, ".dov_n"}, 32'(dov_q.size()), 32'd1);
    check({tag, ".dov_at"}, (dov_q.size() > 0) ? 32'(dov_q[0]) : 32'hFFFF_FFFF,
          32'(1 + CD * (2 * DW + 1)));
    check({tag, ".dov_data"}, (dovd_q.size() > 0) ? 32'(dovd_q[0]) : 32'hFFFF_FFFF, 32'(exp_rx));
    check({tag, ".data_out"}, 32'(if_a.data_out), 32'(exp_rx));
    check({tag, ".busy_fall"}, (busyf_q.size() > 0) ? 32'(busyf_q[0]) : 32'hFFFF_FFFF,
          32'(1 + CD * (2 * DW + 2)));
    check({tag, ".mosi_word"}, mosi_word, 32'(d));
    check({tag, ".slave_rx"}, 32'(s_rx), 32'(d));
    check({tag, ".mosi_moves"}, 32'(mosi_bad), 32'd0);
    check({tag, ".sck_cs_hi"}, 32'(viol), 32'd0);
  endtask

  task automatic frame_b(input string tag, input logic [DW_B-1:0] d);
    int n;
    n = 0;
    while (if_b.busy === 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    rises_b = 0; dov_n_b = 0; dov_at_b = -1; busyf_b = -1; dout_b = '0; mosi_word_b = '0;
    if_b.data_in       = d;
    if_b.data_in_valid = 1'b1;
    t0_b  = cyc;
    mon_b = 1'b1;
    @(posedge clk); #1;
    if_b.data_in_valid = 1'b0;
    if_b.data_in       = DW_B'($urandom);
    repeat (80) @(posedge clk);
    #1;
    mon_b = 1'b0;
    check({tag, ".rises"}, 32'(rises_b), 32'(DW_B));
    check({tag, ".dov_n"}, 32'(dov_n_b), 32'd1);
    check({tag, ".dov_at"}, 32'(dov_at_b), 32'(1 + CD_B * (2 * DW_B + 1)));
    check({tag, ".data"}, 32'(dout_b), 32'(d));
    check({tag, ".mosi_word"}, mosi_word_b, 32'(d));
    check({tag, ".busy_fall"}, 32'(busyf_b), 32'(1 + CD_B * (2 * DW_B + 2)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b2b_t0;
    rst = 1'b1;
    if_a.data_in_valid = 1'b0;
    if_a.data_in       = '0;
    if_b.data_in_valid = 1'b0;
    if_b.data_in       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.cs",   32'(if_a.cs),   32'd1);
    check("rst.sck",  32'(if_a.sck),  32'd0);
    check("rst.mosi", 32'(if_a.mosi), 32'd0);
    check("rst.busy", 32'(if_a.busy), 32'd0);
    check("rst.dov",  32'(if_a.data_out_valid), 32'd0);
    check("rst.dout", 32'(if_a.data_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Loopback and slave-model frames.
    frame_a("loop_a5", 8'hA5, 8'h00, 1'b1, 0);
    frame_a("slave_f0", 8'hF0, 8'h3C, 1'b0, 0);
    // Request during a frame must be dropped.
    frame_a("ignore", 8'h22, 8'h5C, 1'b1, 10);

    // Back-to-back: data_in_valid held high across two accepts.
    wait_idle_a();
    loop_a = 1'b1;
    @(posedge clk); #1;
    clear_mon_a();
    if_a.data_in       = 8'h81;
    if_a.data_in_valid = 1'b1;
    t0 = cyc;
    b2b_t0 = t0;
    mon_en = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      @(posedge clk); #1;
      if (i == 74) if_a.data_in_valid = 1'b0;
    end
    mon_en = 1'b0;
    check("b2b.cs_falls", 32'(csf_q.size()), 32'd2);
    check("b2b.cs_fall2", (csf_q.size() > 1) ? 32'(csf_q[1]) : 32'hFFFF_FFFF, 32'd74);
    check("b2b.cs_gap", (csf_q.size() > 1 && csr_q.size() > 0) ? 32'(csf_q[1] - csr_q[0])
          : 32'hFFFF_FFFF, 32'(CD + 1));
    check("b2b.dov_n", 32'(dov_q.size()), 32'd2);
    check("b2b.dov2_at", (dov_q.size() > 1) ? 32'(dov_q[1]) : 32'hFFFF_FFFF, 32'(73 + 69));
    for (int k = 0; k < dovd_q.size(); k++) begin
      check($sformatf("b2b.data%0d", k), 32'(dovd_q[k]), 32'h81);
    end
    check("b2b.rises", 32'(rise_q.size()), 32'(2 * DW));

    // Reset mid-frame at T+30.
    loop_a = 1'b1;
    start_a(8'hC3);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.cs",   32'(if_a.cs),   32'd1);
    check("midrst.sck",  32'(if_a.sck),  32'd0);
    check("midrst.mosi", 32'(if_a.mosi), 32'd0);
    check("midrst.busy", 32'(if_a.busy), 32'd0);
    check("midrst.dout", 32'(if_a.data_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("midrst.dov_n", 32'(dov_q.size()), 32'd0);
    check("midrst.cs_falls", 32'(csf_q.size()), 32'd1);
    frame_a("after_rst", 8'h5A, 8'h00, 1'b1, 0);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      frame_a($sformatf("rnd%0d", r), DW'($urandom), DW'($urandom),
              1'($urandom_range(0, 1)), 0);
    end

    // Wide / fast instance.
    frame_b("b_beef", 16'hBEEF);
    frame_b("b_rnd", DW_B'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 initiator (CPOL=0, CPHA=0), MSB first. Drives sck, cs and mosi; samples miso.
- Counterpart to the board's SPI slave. Used on a second board or in loopback benches to exercise the slave over the same four-wire link.
- Host side uses the same word handshake as the slave: data_in_valid, data_in, busy, data_out_valid, data_out.
- One full-duplex word per transaction.

Parameters:
- DATA_WIDTH, 8, bits per transaction; must be >= 2.
- CLK_DIV, 4, clk cycles per sck half-period; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in_valid  input  1  request to start a transaction with data_in.
- data_in  input  DATA_WIDTH  word to shift out on mosi.
- busy  output  1  high from accept until the end of the inter-frame gap.
- data_out_valid  output  1  one-cycle pulse: data_out holds the new received word.
- data_out  output  DATA_WIDTH  last word received on miso.
- sck  output  1  SPI clock; idles low.
- cs  output  1  chip select, active-low; idles high.
- mosi  output  1  serial data to the slave.
- miso  input  1  serial data from the slave.

Behaviour:
- Reset values: cs=1, sck=0, mosi=0, busy=0, data_out_valid=0, data_out=0, state=IDLE, all counters=0.
- Asserting rst mid-transaction forces these values immediately. The partial word is discarded and no data_out_valid pulse is produced.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- A half-period counter counts 0..CLK_DIV-1 in every state except IDLE. Each state transition and each sck toggle happens when the counter wraps.
- Accept: in IDLE, when data_in_valid=1 in cycle T, data_in is latched into the tx shift register.
- At T+1: busy=1, cs=0, mosi=data_in[DATA_WIDTH-1], state=SETUP.
- data_in_valid while busy=1 is ignored. data_in is not re-sampled during a transaction.
- Edge k (k = 0..DATA_WIDTH-1):
  - sck rises at cycle T+1+CLK_DIV*(1+2k). miso is sampled in that same clk cycle and shifted into the rx register LSB-side.
  - sck falls at T+1+CLK_DIV*(2+2k). For k < DATA_WIDTH-1, mosi updates in that cycle to bit DATA_WIDTH-2-k.
  - mosi is stable for a full sck period around each rising edge.
- HOLD: entered at the last falling edge. mosi keeps bit 0 and sck stays 0 for CLK_DIV cycles.
- End of HOLD, cycle T+1+CLK_DIV*(2*DATA_WIDTH+1):
  - cs=1, mosi=0.
  - data_out is loaded with the rx register.
  - data_out_valid=1 for exactly this one cycle.
- GAP: cs stays high for CLK_DIV cycles. busy=0 at T+1+CLK_DIV*(2*DATA_WIDTH+2) and the state returns to IDLE.
- The IDLE cycle is the earliest cycle a new data_in_valid is accepted. Minimum cs-high time between frames is CLK_DIV+1 cycles.
- Defaults (8-bit, CLK_DIV=4): cs low T+1, first sck rise T+5, last sck fall T+65, cs high and data_out_valid at T+69, busy low at T+73.
- Exactly DATA_WIDTH sck rising edges per frame. sck is never high while cs=1.
- data_out is stable between data_out_valid pulses.
- miso is not synchronised: sampling happens half an sck period after the slave's launch edge, which is sufficient for CLK_DIV >= 2.

Test Plan:
- Loopback (miso tied to mosi), data_in=0xA5 pulsed at T -> exactly 8 sck rises; mosi sequence 1,0,1,0,0,1,0,1; data_out=0xA5 with a single data_out_valid pulse at T+69; busy falls at T+73.
- Bench slave model returns 0x3C on miso while master sends 0xF0 -> data_out=0x3C; the model captures 0xF0; cs low from T+1 to T+68 inclusive.
- data_in_valid pulsed with 0x11 at T+10 during a frame carrying 0x22 -> pulse ignored: one frame only, mosi carries 0x22, no second cs assertion.
- data_in_valid held high with data_in=0x81 -> back-to-back frames, each accepted in the cycle busy=0; cs high for 5 cycles between frames; every frame received as 0x81 in loopback.
- rst asserted at T+30 -> in the same cycle cs=1, sck=0, mosi=0, busy=0; no data_out_valid; data_out=0. A following 0x5A frame completes correctly.
- CLK_DIV=2, DATA_WIDTH=16, loopback with 0xBEEF -> 16 sck rises; data_out=0xBEEF at T+1+2*33=T+67; busy low at T+69.
